mem_stage_access_ctrl: RTL and testbench
========================================

// Module: mem_stage_access_ctrl
// PURPOSE
//  Sequences data-memory accesses for the MEM stage, driven by the EX/MEM pipeline register outputs.
//  Launches one bus transaction per load/store, waits on a ready handshake and formats load data.
//  Raises stall_o to freeze the PC and all pipeline registers while an access is outstanding.
//  Covers RV32I LB/LH/LW/LBU/LHU/SB/SH/SW on a 32-bit word-addressed bus with byte enables.
// PARAMETERS
//  ADDR_WIDTH      32   width of byte address presented to data memory
//  TIMEOUT_CYCLES  255  max cycles in WAIT without dmem_ready_i before bus error (>=1)
// PORTS
//  clk            in   1           single clock, all state updates on posedge
//  rst            in   1           reset: synchronous, active-high
//  memRead_i      in   1           load in MEM stage (from EX/MEM register)
//  memWrite_i     in   1           store in MEM stage
//  func3_i        in   3           RV32I load/store width/sign code
//  addr_i         in   ADDR_WIDTH  byte address (ALU result)
//  wdata_i        in   32          store data (rs2 value)
//  stall_o        out  1           freeze pipeline registers + PC this cycle (combinational)
//  loadData_o     out  32          formatted load result, valid in DONE cycle
//  misaligned_o   out  1           misaligned access detected this cycle (combinational)
//  busErr_o       out  1           one-cycle pulse: access timed out
//  dmem_req_o     out  1           bus request (registered)
//  dmem_we_o      out  1           1 = write, 0 = read (registered)
//  dmem_addr_o    out  ADDR_WIDTH  word-aligned address, addr_i[1:0] forced to 0
//  dmem_wdata_o   out  32          lane-replicated store data
//  dmem_be_o      out  4           byte enables
//  dmem_ready_i   in   1           bus completes access this cycle
//  dmem_rdata_i   in   32          read data, valid with dmem_ready_i
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0; every registered output is 0.
//   stall_o and misaligned_o are forced to 0 while rst=1.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - op = memRead_i|memWrite_i; if both are set, treat as write.
//   - op & aligned: stall_o=1, register req=1, we, addr, wdata, be; go to WAIT.
//   - op & misaligned: misaligned_o=1, stall_o=0, no request, stay in IDLE.
//   - No op: stall_o=0.
//  WAIT:
//   - stall_o=1; req/we/addr/wdata/be held stable; counter increments each cycle.
//   - dmem_ready_i=1: req<=0, counter<=0, go to DONE.
//     For a read, loadData_o<=format(dmem_rdata_i).
//   - Counter reaches TIMEOUT_CYCLES-1 without ready: req<=0, loadData_o<=0,
//     busErr_o<=1 for one cycle, go to DONE. Ready on that same cycle wins; no error.
//  DONE:
//   - stall_o=0 for exactly one cycle; pipeline advances once.
//   - loadData_o is held until the next load completes.
//   - Next state is IDLE unconditionally.
//  Minimum access latency: 3 cycles (IDLE, WAIT with ready, DONE). Stall lasts 2 cycles in the best case.
//  dmem_ready_i is ignored outside WAIT.
//  Alignment: half (func3[1:0]=01) needs addr[0]=0; word (10) needs addr[1:0]=0; byte is always aligned.
//   func3[1:0]=11 is treated as misaligned.
//  Store lanes:
//   - SB: be=4'b0001<<addr[1:0], wdata={4{wdata_i[7:0]}}.
//   - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata_i[15:0]}}.
//   - SW: be=4'b1111, wdata=wdata_i.
//   - Reads drive be for the accessed lanes.
//  Load format: sh=dmem_rdata_i>>(8*addr[1:0]).
//   - LB: sext(sh[7:0]); LBU: zext(sh[7:0]).
//   - LH: sext(sh[15:0]); LHU: zext(sh[15:0]).
//   - LW: sh (a shift of 0).
//  Reset mid-access: next cycle in IDLE with req=0. The bus must discard the abandoned access.
// TESTING
//  LW addr=0x100, ready on 1st WAIT cycle, rdata=0xDEADBEEF
//   -> req 1 cycle, stall_o 1,1,0; loadData_o=0xDEADBEEF in DONE.
//  LB addr=0x103, rdata=0x80FF_0000 -> loadData_o=0xFFFFFF80.
//   Same access as LBU -> 0x00000080.
//  SH addr=0x202, wdata_i=0x1234ABCD -> dmem_addr_o=0x200, be=4'b1100, dmem_wdata_o=0xABCDABCD, we=1.
//  LW addr=0x101 -> misaligned_o=1, dmem_req_o stays 0, stall_o=0.
//  LW with ready never asserted, TIMEOUT_CYCLES=4 -> WAIT for 4 cycles, busErr_o pulse, loadData_o=0, then IDLE.
//  rst asserted in 2nd WAIT cycle -> next cycle req=0, stall_o=0, state IDLE; the next LW completes normally.

Source files
------------

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory sequencer: one bus access per load/store, 3-cycle minimum (IDLE, WAIT, DONE).
// Backpressure: stall_o freezes the pipeline until dmem_ready_i or a timeout. A misaligned op is flagged and never issued.
module mem_stage_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead_i,
  input  logic                  memWrite_i,
  input  logic [2:0]            func3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic [31:0]           loadData_o,
  output logic                  misaligned_o,
  output logic                  busErr_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [31:0]           dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_ready_i,
  input  logic [31:0]           dmem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  rd_q, rd_d;
  logic [31:0]           load_q, load_d;
  logic                  buserr_q, buserr_d;

  logic                  op;
  logic                  aligned;
  logic [3:0]            be_new;
  logic [31:0]           wdata_new;
  logic [31:0]           rdata_sh;
  logic [31:0]           load_fmt;
  logic                  stall;
  logic                  mis;

  assign op = memRead_i | memWrite_i;

  always_comb begin
    aligned   = 1'b0;
    be_new    = 4'b0000;
    wdata_new = 32'd0;
    case (func3_i[1:0])
      2'b00: begin
        aligned   = 1'b1;
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr_i[0];
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        aligned   = (addr_i[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
      default: begin
        aligned   = 1'b0;
        be_new    = 4'b0000;
        wdata_new = 32'd0;
      end
    endcase
  end

  // The byte offset is kept aside because dmem_addr_o drops the low two bits.
  assign rdata_sh = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_fmt = rdata_sh;
    case (f3_q)
      3'b000:  load_fmt = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_fmt = {24'd0, rdata_sh[7:0]};
      3'b001:  load_fmt = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_fmt = {16'd0, rdata_sh[15:0]};
      default: load_fmt = rdata_sh;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    load_d   = load_q;
    buserr_d = 1'b0;
    stall    = 1'b0;
    mis      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (aligned) begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = memWrite_i;
            rd_d    = ~memWrite_i;
            addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = memWrite_i ? wdata_new : 32'd0;
            be_d    = be_new;
            f3_d    = func3_i;
            off_d   = addr_i[1:0];
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            mis = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem_ready_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
          if (rd_q) begin
            load_d = load_fmt;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d    = 1'b0;
          cnt_d    = '0;
          load_d   = 32'd0;
          buserr_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'b0000;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      rd_q     <= 1'b0;
      load_q   <= 32'd0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      buserr_q <= buserr_d;
    end
  end

  assign stall_o      = stall & ~rst;
  assign misaligned_o = mis & ~rst;
  assign busErr_o     = buserr_q;
  assign loadData_o   = load_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: directed cases plus random loads/stores against a transaction-level model.
module tb_mem_stage_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead_i, memWrite_i;
  logic [2:0]  func3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, misaligned_o, busErr_o;
  logic [31:0] loadData_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_load = 32'd0;

  mem_stage_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i), .func3_i(func3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .loadData_o(loadData_o), .misaligned_o(misaligned_o),
    .busErr_o(busErr_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memRead_i    = 1'b0;
    memWrite_i   = 1'b0;
    func3_i      = 3'b000;
    addr_i       = 32'd0;
    wdata_i      = 32'd0;
    dmem_ready_i = 1'b0;
    dmem_rdata_i = 32'd0;
  endtask

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
    longint sh;
    longint v;
    int sz;
    sz = 1 << f3[1:0];
    sh = rdata;
    sh = sh >> (8 * (a % 4));
    if (sz == 4) begin
      v = sh;
    end else begin
      v = sh % (64'sd1 << (8 * sz));
      if (f3[2] == 1'b0 && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
    end
    return v[31:0];
  endfunction

  // n = WAIT cycle on which ready arrives (1-based); n > TO means the bus never answers.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int n, input logic [31:0] rdata, input string nm);
    bit op, mis, timed_out, is_read;
    int sz, waits;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_ld;
    op        = rd | wr;
    is_read   = rd & ~wr;
    sz        = 1 << f3[1:0];
    mis       = op && ((f3[1:0] == 2'b11) || (a % sz != 0));
    e_be      = 4'((32'd1 << sz) - 1) << (a % 4);
    e_wd      = (sz == 1) ? a * 0 + wd[7:0] * 32'h01010101 :
                (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    e_ld      = model_load(f3, a, rdata);
    timed_out = (n > TO);
    waits     = timed_out ? TO : n;

    memRead_i = rd; memWrite_i = wr; func3_i = f3; addr_i = a; wdata_i = wd;
    dmem_ready_i = 1'($urandom % 2);
    dmem_rdata_i = $urandom;
    #1;
    total++;
    if ({stall_o, misaligned_o, dmem_req_o} !== {op && !mis, mis, 1'b0}) begin
      bad++;
      $display("FAIL %s idle stall/mis/req got=%b%b%b exp=%b%b%b", nm, stall_o, misaligned_o,
               dmem_req_o, op && !mis, mis, 1'b0);
    end
    total++;
    if (loadData_o !== exp_load) begin
      bad++;
      $display("FAIL %s held loadData got=%h exp=%h", nm, loadData_o, exp_load);
    end
    tick();

    if (!op || mis) begin
      dmem_ready_i = 1'b0;
      #1;
      total++;
      if ({dmem_req_o, stall_o, busErr_o} !== 3'b000) begin
        bad++;
        $display("FAIL %s no-issue req/stall/err got=%b%b%b exp=000", nm, dmem_req_o, stall_o, busErr_o);
      end
      idle_inputs();
      tick();
      return;
    end

    for (int w = 1; w <= waits; w++) begin
      dmem_ready_i = (w == n);
      dmem_rdata_i = (w == n) ? rdata : $urandom;
      #1;
      total++;
      if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, busErr_o} !==
          {1'b1, 1'b1, wr, a & 32'hFFFF_FFFC, e_be, 1'b0}) begin
        bad++;
        $display("FAIL %s wait%0d stall=%b req=%b we=%b addr=%h be=%b err=%b exp stall=1 req=1 we=%b addr=%h be=%b err=0",
                 nm, w, stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, busErr_o,
                 wr, a & 32'hFFFF_FFFC, e_be);
      end
      if (wr) begin
        total++;
        if (dmem_wdata_o !== e_wd) begin
          bad++;
          $display("FAIL %s wait%0d wdata got=%h exp=%h", nm, w, dmem_wdata_o, e_wd);
        end
      end
      tick();
    end

    dmem_ready_i = 1'($urandom % 2);
    dmem_rdata_i = $urandom;
    if (timed_out) exp_load = 32'd0;
    else if (is_read) exp_load = e_ld;
    #1;
    total++;
    if ({stall_o, dmem_req_o, busErr_o} !== {1'b0, 1'b0, timed_out}) begin
      bad++;
      $display("FAIL %s done stall/req/err got=%b%b%b exp=00%b", nm, stall_o, dmem_req_o, busErr_o, timed_out);
    end
    total++;
    if (loadData_o !== exp_load) begin
      bad++;
      $display("FAIL %s done loadData got=%h exp=%h", nm, loadData_o, exp_load);
    end
    idle_inputs();
    tick();
    total++;
    if (busErr_o !== 1'b0) begin
      bad++;
      $display("FAIL %s busErr pulse too long got=%b exp=0", nm, busErr_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    memRead_i = 1'b1; func3_i = 3'b010; addr_i = 32'h101;
    #1;
    total++;
    if ({stall_o, misaligned_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset misaligned-in-reset stall/mis got=%b%b exp=00", stall_o, misaligned_o);
    end
    addr_i = 32'h100;
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset stall-in-reset got=%b exp=0", stall_o);
    end
    total++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, loadData_o, busErr_o} !== 103'd0) begin
      bad++;
      $display("FAIL reset registered outputs req=%b we=%b addr=%h wd=%h be=%b ld=%h err=%b exp all 0",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, loadData_o, busErr_o);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    exp_load = 32'd0;
    tick();
  endtask

  task automatic test_directed();
    do_access(1, 0, 3'b010, 32'h100, 32'd0, 1, 32'hDEADBEEF, "lw_basic");
    do_access(1, 0, 3'b000, 32'h103, 32'd0, 1, 32'h80FF_0000, "lb_sext");
    do_access(1, 0, 3'b100, 32'h103, 32'd0, 2, 32'h80FF_0000, "lbu_zext");
    do_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'd0, "sh_upper");
    do_access(1, 0, 3'b010, 32'h101, 32'd0, 1, 32'd0, "lw_misaligned");
    do_access(1, 0, 3'b001, 32'h103, 32'd0, 1, 32'd0, "lh_misaligned");
    do_access(1, 0, 3'b011, 32'h100, 32'd0, 1, 32'd0, "f3_11_misaligned");
    do_access(1, 0, 3'b001, 32'h102, 32'd0, 3, 32'h8001_7FFF, "lh_upper");
    do_access(1, 0, 3'b010, 32'h300, 32'd0, TO + 1, 32'd0, "lw_timeout");
    do_access(1, 0, 3'b101, 32'h302, 32'd0, TO, 32'h9ABC_0000, "lhu_ready_last");
    do_access(0, 1, 3'b000, 32'h401, 32'hAAAA_AA5C, 1, 32'd0, "sb_lane1");
    do_access(1, 1, 3'b010, 32'h500, 32'hCAFE_F00D, 2, 32'h1111_1111, "rd_wr_is_write");
    do_access(0, 0, 3'b010, 32'h500, 32'd0, 1, 32'd0, "no_op");
  endtask

  task automatic test_reset_mid();
    memRead_i = 1'b1; func3_i = 3'b010; addr_i = 32'h600;
    dmem_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    exp_load = 32'd0;
    #1;
    total++;
    if ({dmem_req_o, stall_o, busErr_o, loadData_o} !== 35'd0) begin
      bad++;
      $display("FAIL reset_mid req/stall/err got=%b%b%b ld=%h exp 000 ld=0", dmem_req_o, stall_o, busErr_o, loadData_o);
    end
    tick();
    do_access(1, 0, 3'b010, 32'h604, 32'd0, 1, 32'h0BAD_F00D, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5];
    logic [2:0] f3;
    int kind;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 9) f3 = 3'b011;
      else if (kind < 5) f3 = ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      do_access(kind < 5 || kind == 8, kind >= 5, f3, 32'h1000 + 32'($urandom_range(0, 63)),
                $urandom, $urandom_range(1, TO + 1), $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    do_access(0, 1, 3'b010, 32'h700, 32'h0102_0304, 1, 32'd0, "b2b_sw");
    do_access(1, 0, 3'b000, 32'h702, 32'd0, 1, 32'h0055_0000, "b2b_lb");
    do_access(1, 0, 3'b001, 32'h700, 32'd0, 1, 32'h0000_F123, "b2b_lh");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
